// File: rtl/arena_frame_rx.sv
// -----------------------------------------------------------------------------
// arena_frame_rx
//
// Receive side of the serial game-state link. Bytes from the UART receiver are
// reassembled into one 18-byte snapshot frame:
//   byte0      HEADER sync byte
//   byte1..13  arena map, LSB first (byte13 bits 7:4 ignored)
//   byte14     {Ay, Ax}
//   byte15     {By, Bx}
//   byte16     {unused[3:0], healthB, healthA}
//   byte17     XOR of bytes 1..16
// A frame whose checksum matches is published to the outputs in one cycle.
// A corrupt or stalled frame is dropped and the outputs keep their values.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   i_rx_data      received byte
//   i_rx_valid     one-cycle strobe, i_rx_data valid this cycle
//   o_arena_0      arena map, bit index = y*10+x
//   o_playerAx/Ay  player A coordinates
//   o_playerBx/By  player B coordinates
//   o_healthA/B    player health
//   o_frame_valid  one-cycle pulse when the outputs update
//   o_frame_err    one-cycle pulse when a frame is dropped
//   o_busy         high while a frame is partially received
// -----------------------------------------------------------------------------
module arena_frame_rx #(
   parameter logic [7:0] HEADER         = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter int         TO_W           = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [99:0] o_arena_0,
   output logic [3:0]  o_playerAx,
   output logic [3:0]  o_playerAy,
   output logic [3:0]  o_playerBx,
   output logic [3:0]  o_playerBy,
   output logic [1:0]  o_healthA,
   output logic [1:0]  o_healthB,
   output logic        o_frame_valid,
   output logic        o_frame_err,
   output logic        o_busy
);

   localparam logic [1:0] S_HUNT    = 2'd0;
   localparam logic [1:0] S_PAYLOAD = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;

   // The counter holds the number of idle cycles already elapsed, so the
   // cycle in which it equals TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th cycle
   // since the last accepted byte.
   localparam logic [TO_W-1:0] TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      LAST_PAYLOAD = 4'd15;

   logic [1:0]      state;
   logic [3:0]      byte_cnt;
   logic [7:0]      xor_acc;
   logic [TO_W-1:0] to_cnt;

   // Shadow copy of the frame under reception; only published on a good
   // checksum, so it is never cleared.
   logic [99:0]     arena_sh;
   logic [7:0]      pos_a_sh;
   logic [7:0]      pos_b_sh;
   logic [3:0]      health_sh;

   logic            in_frame;
   logic            to_hit;
   logic            take_payload;

   assign in_frame     = (state != S_HUNT);
   // Timeout has priority over a byte arriving in the same cycle.
   assign to_hit       = in_frame && (to_cnt == TO_LAST);
   assign take_payload = i_rx_valid && !to_hit && (state == S_PAYLOAD);
   assign o_busy       = in_frame;

   // Payload capture into the shadow registers, indexed by byte count.
   always_ff @(posedge clk) begin
      if (take_payload) begin
         for (int k = 0; k < 12; k++) begin
            if (byte_cnt == 4'(k)) arena_sh[8*k +: 8] <= i_rx_data;
         end
         case (byte_cnt)
            4'd12:   arena_sh[99:96] <= i_rx_data[3:0];
            4'd13:   pos_a_sh        <= i_rx_data;
            4'd14:   pos_b_sh        <= i_rx_data;
            4'd15:   health_sh       <= i_rx_data[3:0];
            default: ;
         endcase
      end
   end

   // Frame state machine, checksum, timeout and published outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_HUNT;
         byte_cnt      <= 4'd0;
         xor_acc       <= 8'd0;
         to_cnt        <= '0;
         o_arena_0     <= 100'd0;
         o_playerAx    <= 4'd1;
         o_playerAy    <= 4'd1;
         o_playerBx    <= 4'd8;
         o_playerBy    <= 4'd8;
         o_healthA     <= 2'd3;
         o_healthB     <= 2'd3;
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;
      end else begin
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;
         if (to_hit) begin
            state       <= S_HUNT;
            to_cnt      <= '0;
            o_frame_err <= 1'b1;
         end else begin
            if (in_frame) to_cnt <= i_rx_valid ? '0 : to_cnt + TO_W'(1);
            if (i_rx_valid) begin
               case (state)
                  S_HUNT: begin
                     if (i_rx_data == HEADER) begin
                        state    <= S_PAYLOAD;
                        byte_cnt <= 4'd0;
                        xor_acc  <= 8'd0;
                        to_cnt   <= '0;
                     end
                  end
                  S_PAYLOAD: begin
                     xor_acc  <= xor_acc ^ i_rx_data;
                     byte_cnt <= byte_cnt + 4'd1;
                     if (byte_cnt == LAST_PAYLOAD) state <= S_CHECK;
                  end
                  S_CHECK: begin
                     state <= S_HUNT;
                     if (i_rx_data == xor_acc) begin
                        o_arena_0     <= arena_sh;
                        o_playerAx    <= pos_a_sh[3:0];
                        o_playerAy    <= pos_a_sh[7:4];
                        o_playerBx    <= pos_b_sh[3:0];
                        o_playerBy    <= pos_b_sh[7:4];
                        o_healthA     <= health_sh[1:0];
                        o_healthB     <= health_sh[3:2];
                        o_frame_valid <= 1'b1;
                     end else begin
                        o_frame_err   <= 1'b1;
                     end
                  end
                  default: state <= S_HUNT;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_arena_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_arena_frame_rx
//
// Self-checking bench for arena_frame_rx. Frames are built by the bench from
// an expected snapshot; good frames push that snapshot to a scoreboard queue
// which a monitor pops on every o_frame_valid pulse. Scenario tasks check
// reset state, dropped frames, back-to-back frames, timeout and mid-frame
// reset. The DUT runs with TIMEOUT_CYCLES = 100.
// -----------------------------------------------------------------------------
module tb_arena_frame_rx;

   typedef struct packed {
      logic [99:0] ar;
      logic [3:0]  ax;
      logic [3:0]  ay;
      logic [3:0]  bx;
      logic [3:0]  by;
      logic [1:0]  ha;
      logic [1:0]  hb;
   } snap_t;

   localparam snap_t RESET_SNAP = {100'd0, 4'd1, 4'd1, 4'd8, 4'd8, 2'd3, 2'd3};

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [99:0] arena;
   logic [3:0]  pax, pay, pbx, pby;
   logic [1:0]  ha, hb;
   logic        frame_valid, frame_err, busy;

   arena_frame_rx #(
      .HEADER(8'hA5),
      .TIMEOUT_CYCLES(100),
      .TO_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_rx_data(rx_data),
      .i_rx_valid(rx_valid),
      .o_arena_0(arena),
      .o_playerAx(pax),
      .o_playerAy(pay),
      .o_playerBx(pbx),
      .o_playerBy(pby),
      .o_healthA(ha),
      .o_healthB(hb),
      .o_frame_valid(frame_valid),
      .o_frame_err(frame_err),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   snap_t      obs;
   assign obs = {arena, pax, pay, pbx, pby, ha, hb};

   snap_t      exp_q[$];
   snap_t      cur;
   snap_t      bld;
   snap_t      mon_e;
   logic [7:0] frm[18];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_valid = 0;
   int         n_err   = 0;

   // Scoreboard monitor, sampled 1 time unit after the falling edge.
   always @(negedge clk) begin
      #1;
      if (frame_valid === 1'b1) begin
         n_valid++;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_contents: got unexpected o_frame_valid, required no pulse");
         end else begin
            mon_e = exp_q.pop_front();
            if (obs !== mon_e) begin
               n_fail++;
               $display("FAIL frame_contents: got %h, required %h", obs, mon_e);
            end
         end
      end
      if (frame_err === 1'b1) n_err++;
      if (frame_valid === 1'b1 && frame_err === 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL pulse_exclusive: got valid=1 err=1, required at most one");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic snap_t rand_snap();
      snap_t        r;
      logic [127:0] w;
      w    = {$urandom(), $urandom(), $urandom(), $urandom()};
      r.ar = w[99:0];
      r.ax = 4'($urandom_range(9, 0));
      r.ay = 4'($urandom_range(9, 0));
      r.bx = 4'($urandom_range(9, 0));
      r.by = 4'($urandom_range(9, 0));
      r.ha = 2'($urandom_range(3, 0));
      r.hb = 2'($urandom_range(3, 0));
      return r;
   endfunction

   task automatic build_frame(input snap_t s, input logic [3:0] junk);
      bld    = s;
      frm[0] = 8'hA5;
      for (int k = 1; k <= 12; k++) frm[k] = s.ar[8*(k-1) +: 8];
      frm[13] = {junk, s.ar[99:96]};
      frm[14] = {s.ay, s.ax};
      frm[15] = {s.by, s.bx};
      frm[16] = {junk, s.hb, s.ha};
      frm[17] = 8'h00;
      for (int k = 1; k <= 16; k++) frm[17] = frm[17] ^ frm[k];
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Sends frm[0..17]; leaves rx_valid high so a following frame can be
   // back-to-back. Checks the pulse right after the checksum edge.
   task automatic send_frame(input string name);
      logic [7:0] x;
      logic       good;
      x = 8'h00;
      for (int k = 1; k <= 16; k++) x = x ^ frm[k];
      good = (x == frm[17]);
      if (good) exp_q.push_back(bld);
      for (int k = 0; k < 18; k++) send_byte(frm[k]);
      n_tests++;
      if ({frame_valid, frame_err} !== {good, !good}) begin
         n_fail++;
         $display("FAIL %s_pulse: got valid=%b err=%b, required valid=%b err=%b",
                  name, frame_valid, frame_err, good, !good);
      end
      if (good) cur = bld;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(10);
      cur = RESET_SNAP;
      n_tests++;
      if (obs !== RESET_SNAP) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, required %h", obs, RESET_SNAP);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b, required 0", busy);
      end
      n_tests++;
      if (n_valid != 0 || n_err != 0) begin
         n_fail++;
         $display("FAIL reset_pulses: got valid=%0d err=%0d, required 0 0", n_valid, n_err);
      end
   endtask

   task automatic test_good_frame();
      snap_t s;
      int    v0;
      send_byte(8'h00);
      send_byte(8'h13);
      idle(1);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hunt_ignore: got busy=%b, required 0", busy);
      end
      s     = RESET_SNAP;
      s.ar  = 100'd0;
      s.ar[11] = 1'b1;
      s.ar[88] = 1'b1;
      s.ax = 4'd1; s.ay = 4'd2; s.bx = 4'd8; s.by = 4'd7;
      s.ha = 2'd2; s.hb = 2'd1;
      v0 = n_valid;
      build_frame(s, 4'h0);
      send_frame("good");
      idle(2);
      n_tests++;
      if (obs !== s) begin
         n_fail++;
         $display("FAIL good_outputs: got %h, required %h", obs, s);
      end
      n_tests++;
      if (n_valid - v0 != 1) begin
         n_fail++;
         $display("FAIL good_count: got %0d pulses, required 1", n_valid - v0);
      end
   endtask

   task automatic test_bad_checksum();
      snap_t s;
      int    v0, e0;
      s = cur;
      v0 = n_valid; e0 = n_err;
      build_frame(s, 4'h0);
      frm[17] = 8'h5A;
      send_frame("bad_5a");
      idle(2);
      n_tests++;
      if (n_err - e0 != 1 || n_valid != v0) begin
         n_fail++;
         $display("FAIL bad_5a_count: got err=%0d valid=%0d, required 1 0", n_err - e0, n_valid - v0);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_5a_busy: got %b, required 0", busy);
      end
      // Different contents with a corrupt checksum must not leak out.
      e0 = n_err;
      build_frame(rand_snap(), 4'hF);
      frm[17] = frm[17] ^ 8'h01;
      send_frame("bad_rand");
      idle(2);
      n_tests++;
      if (obs !== cur) begin
         n_fail++;
         $display("FAIL bad_hold: got %h, required %h", obs, cur);
      end
      n_tests++;
      if (n_err - e0 != 1) begin
         n_fail++;
         $display("FAIL bad_rand_count: got err=%0d, required 1", n_err - e0);
      end
   endtask

   task automatic test_back_to_back();
      snap_t s1, s2;
      int    v0;
      v0 = n_valid;
      s1 = rand_snap();
      s1.ar[31:24] = 8'hA5;
      build_frame(s1, 4'h5);
      send_frame("b2b_first");
      n_tests++;
      if (arena[31:24] !== 8'hA5) begin
         n_fail++;
         $display("FAIL header_as_data: got %h, required a5", arena[31:24]);
      end
      s2 = rand_snap();
      build_frame(s2, 4'hA);
      send_frame("b2b_second");
      idle(2);
      n_tests++;
      if (n_valid - v0 != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d pulses, required 2", n_valid - v0);
      end
      n_tests++;
      if (obs !== s2) begin
         n_fail++;
         $display("FAIL b2b_outputs: got %h, required %h", obs, s2);
      end
   endtask

   task automatic test_timeout();
      int   e0, v0;
      logic early;
      e0 = n_err; v0 = n_valid;
      build_frame(rand_snap(), 4'h0);
      for (int k = 0; k < 8; k++) send_byte(frm[k]);
      rx_valid = 1'b0;
      early = 1'b0;
      for (int i = 1; i < 100; i++) begin
         @(negedge clk);
         if (frame_err !== 1'b0) early = 1'b1;
      end
      n_tests++;
      if (early) begin
         n_fail++;
         $display("FAIL timeout_early: got err before 100 cycles, required none");
      end
      @(negedge clk);
      n_tests++;
      if (frame_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_at_100: got err=%b busy=%b, required 1 0", frame_err, busy);
      end
      @(negedge clk);
      n_tests++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_single: got err=%b, required 0", frame_err);
      end
      // Header arriving in the timeout cycle is discarded.
      build_frame(rand_snap(), 4'h0);
      for (int k = 0; k < 5; k++) send_byte(frm[k]);
      idle(99);
      send_byte(8'hA5);
      rx_valid = 1'b0;
      n_tests++;
      if (frame_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_collide: got err=%b busy=%b, required 1 0", frame_err, busy);
      end
      idle(1);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_collide_hunt: got busy=%b, required 0", busy);
      end
      build_frame(rand_snap(), 4'h3);
      send_frame("after_timeout");
      idle(2);
      n_tests++;
      if (n_err - e0 != 2 || n_valid - v0 != 1 || obs !== cur) begin
         n_fail++;
         $display("FAIL timeout_recover: got err=%0d valid=%0d out=%h, required 2 1 %h",
                  n_err - e0, n_valid - v0, obs, cur);
      end
   endtask

   task automatic test_reset_midframe();
      snap_t s;
      int    e0, v0;
      s    = RESET_SNAP;
      s.ar = {4'h3, 96'h11223344_55667788_99AABBCC};
      s.ax = 4'd2; s.ay = 4'd3; s.bx = 4'd4; s.by = 4'd5;
      s.ha = 2'd1; s.hb = 2'd2;
      build_frame(s, 4'h0);
      for (int k = 0; k < 9; k++) send_byte(frm[k]);
      rx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      e0 = n_err; v0 = n_valid;
      for (int k = 9; k < 18; k++) send_byte(frm[k]);
      idle(3);
      cur = RESET_SNAP;
      n_tests++;
      if (n_err != e0 || n_valid != v0) begin
         n_fail++;
         $display("FAIL rst_mid_pulses: got err=%0d valid=%0d, required 0 0", n_err - e0, n_valid - v0);
      end
      n_tests++;
      if (obs !== RESET_SNAP || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %h busy=%b, required %h busy=0", obs, busy, RESET_SNAP);
      end
      build_frame(rand_snap(), 4'h0);
      send_frame("after_rst");
      idle(2);
      n_tests++;
      if (obs !== cur) begin
         n_fail++;
         $display("FAIL rst_mid_recover: got %h, required %h", obs, cur);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_back_to_back();
      test_timeout();
      test_reset_midframe();
      idle(2);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
